// File: rtl/m1m3_pkg.sv
// m1m3_pkg: shared types and sizing helpers for the M1->M3 ready/echo link
package m1m3_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_RELEASE, S_GAP, S_ISOL} m1_seq_state_e;
  localparam int M1M3_ECHO_LAT = 1;
  // the phase timer is shared by the timeout and the gap, so it must hold the larger of the two
  function automatic int tmr_w(int timeout_cyc, int gap_cyc);
    return $clog2((timeout_cyc > gap_cyc ? timeout_cyc : gap_cyc) + 1);
  endfunction
endpackage

// File: rtl/m1_phase_timer.sv
// m1_phase_timer: loadable down-counter, expired while it sits at zero
module m1_phase_timer #(
  parameter int W = 4
) (
  input  logic         ck,
  input  logic         srst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge ck)
    if (!srst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/m1_ready_seq.sv
// m1_ready_seq: four-phase ready/echo producer with timeout, gap and isolation abort
module m1_ready_seq import m1m3_pkg::*; #(
  parameter int TIMEOUT_CYC = 15,
  parameter int GAP_CYC     = 2,
  parameter int CNT_W       = 16
) (
  input  logic             ck,
  input  logic             srst_n,
  input  logic             isolate_m1m3,
  input  logic             start,
  input  logic             ack_in,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             aborted,
  output logic [CNT_W-1:0] xfer_count
);
  localparam int TW = tmr_w(TIMEOUT_CYC, GAP_CYC);
  localparam logic [TW-1:0] TO_LD  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYC);
  m1_seq_state_e state, state_nx;
  logic          expired, fin, tmo, abrt, ld;
  logic [TW-1:0] ld_val;
  always_comb begin
    state_nx = state;
    fin      = 1'b0;
    tmo      = 1'b0;
    abrt     = 1'b0;
    unique case (state)
      S_IDLE:    state_nx = isolate_m1m3 ? S_ISOL : start ? S_ASSERT : S_IDLE;
      S_ASSERT: begin
        abrt     = isolate_m1m3;
        tmo      = !isolate_m1m3 && !ack_in && expired;
        state_nx = isolate_m1m3 ? S_ISOL : ack_in ? S_RELEASE : expired ? S_GAP : S_ASSERT;
      end
      S_RELEASE: begin
        abrt     = isolate_m1m3;
        fin      = !isolate_m1m3 && !ack_in;
        tmo      = !isolate_m1m3 && ack_in && expired;
        state_nx = isolate_m1m3 ? S_ISOL : (!ack_in || expired) ? S_GAP : S_RELEASE;
      end
      S_GAP:     state_nx = isolate_m1m3 ? S_ISOL : expired ? S_IDLE : S_GAP;
      S_ISOL:    state_nx = (!isolate_m1m3 && !ack_in) ? S_GAP : S_ISOL;
      default:   state_nx = S_IDLE;
    endcase
  end
  // every state change restarts the timer; only ASSERT/RELEASE/GAP ever look at it
  assign ld     = state_nx != state;
  assign ld_val = state_nx == S_GAP ? GAP_LD : TO_LD;
  m1_phase_timer #(.W(TW)) u_tmr (
    .ck       (ck),
    .srst_n   (srst_n),
    .load     (ld),
    .load_val (ld_val),
    .expired  (expired)
  );
  always_ff @(posedge ck)
    if (!srst_n) begin
      state       <= S_IDLE;
      data_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      aborted     <= 1'b0;
      xfer_count  <= '0;
    end else begin
      state       <= state_nx;
      data_ready  <= state_nx == S_ASSERT;
      busy        <= state_nx != S_IDLE;
      done        <= fin;
      aborted     <= abrt;
      timeout_err <= tmo || (timeout_err && !(state == S_IDLE && state_nx == S_ASSERT));
      xfer_count  <= xfer_count + CNT_W'(fin);
    end
endmodule
